// File: rtl/sd_cic_decimator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_cic_decimator_pkg
// Description : Shared definitions for the sigma-delta CIC decimator: filter
//               order, output width formula and the bit-to-(+/-1) mapping
//               used by both the receiver and any modulator-side model.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_cic_decimator_pkg;

    // Number of integrator and comb stages in each channel.
    localparam int CIC_ORDER = 3;

    // Output width that holds +/-R^CIC_ORDER with one guard bit and a sign bit.
    function automatic int cic_outwidth(input int log2r);
        return CIC_ORDER * log2r + 2;
    endfunction

    // Bitstream symbol mapping: 1 -> +1, 0 -> -1, as a 2-bit signed value.
    function automatic logic signed [1:0] sd_to_pm1(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cic_channel.sv
`default_nettype none
// ============================================================================
// Module      : sd_cic_channel
// Description : One third-order CIC decimator channel. Integrators run every
//               cycle; the comb section is combinational and its delay
//               registers advance only on the decimation strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cic_channel
    import sd_cic_decimator_pkg::*;
#(
    parameter int  LOG2R    = 6,
    localparam int OUTWIDTH = cic_outwidth(LOG2R)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sd_bit,
    input  logic                       dec,
    output logic signed [OUTWIDTH-1:0] comb_out
);

    logic signed [1:0]          w_pm;
    logic signed [OUTWIDTH-1:0] w_x;
    logic signed [OUTWIDTH-1:0] r_i1, r_i2, r_i3;
    logic signed [OUTWIDTH-1:0] r_d1, r_d2, r_d3;
    logic signed [OUTWIDTH-1:0] w_c1, w_c2, w_c3;

    assign w_pm = sd_to_pm1(sd_bit);
    assign w_x  = {{(OUTWIDTH-2){w_pm[1]}}, w_pm};

    // Comb chain sees the pre-update i3; wrap-around cancels integrator overflow.
    assign w_c1     = r_i3 - r_d1;
    assign w_c2     = w_c1 - r_d2;
    assign w_c3     = w_c2 - r_d3;
    assign comb_out = w_c3;

    // Pipelined integrators: each stage accumulates the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else begin
            r_i1 <= r_i1 + w_x;
            r_i2 <= r_i2 + r_i1;
            r_i3 <= r_i3 + r_i2;
        end
    end

    // Comb delay registers advance once per decimated sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else if (dec) begin
            r_d1 <= r_i3;
            r_d2 <= w_c1;
            r_d3 <= w_c2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : sd_cic_decimator
// Description : Two-channel sigma-delta bitstream receiver. Each bit of sd_in
//               feeds a CIC3 decimator (ratio 2^LOG2R); decimated pairs are
//               held in a 1-deep valid/ready register with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cic_decimator
    import sd_cic_decimator_pkg::*;
#(
    parameter int  LOG2R    = 6,
    localparam int OUTWIDTH = cic_outwidth(LOG2R)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 sd_in,
    output logic signed [OUTWIDTH-1:0] out0_data,
    output logic signed [OUTWIDTH-1:0] out1_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun
);

    logic [LOG2R-1:0]           r_cnt;
    logic                       w_dec;
    logic signed [OUTWIDTH-1:0] w_c3 [2];
    logic signed [OUTWIDTH-1:0] r_data0, r_data1;
    logic                       r_valid;
    logic                       r_overrun;

    // Strobe on the last phase of each decimation period (R-1 is all ones).
    assign w_dec = (r_cnt == {LOG2R{1'b1}});

    // Phase counter wraps naturally at R.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            sd_cic_channel #(
                .LOG2R(LOG2R)
            ) u_channel (
                .clk     (clk),
                .reset   (reset),
                .sd_bit  (sd_in[ch]),
                .dec     (w_dec),
                .comb_out(w_c3[ch])
            );
        end
    endgenerate

    // Output register: a strobe always loads a new pair; an unaccepted pending
    // pair being replaced raises the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data0   <= '0;
            r_data1   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_dec) begin
            r_data0 <= w_c3[0];
            r_data1 <= w_c3[1];
            r_valid <= 1'b1;
            if (r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out0_data = r_data0;
    assign out1_data = r_data1;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cic_decimator
// Description : Self-checking bench for sd_cic_decimator (LOG2R = 6):
//               table of constant/alternating bitstream vectors plus
//               handshake, overrun, mid-run reset and oscillator sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cic_decimator;

    localparam int  OW = 20;          // 3*6+2
    localparam real PI = 3.14159265358979;

    typedef struct {
        int mode;   // 0: sd=11, 1: sd=00, 2: bit0 alternating (1 first), bit1=1
        int idx;    // which valid (1-based) after reset
        int exp0;
        int exp1;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           sd_in = 2'b00;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out0_data, out1_data;
    logic                 out_valid, overrun;

    int  total  = 0;
    int  passed = 0;
    int  mode   = 0;
    int  n      = 0;
    int  osc_n  = 0;
    real acc0   = 0.0;
    real acc1   = 0.0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    sd_cic_decimator #(
        .LOG2R(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sd_in    (sd_in),
        .out0_data(out0_data),
        .out1_data(out1_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    // Drive the bitstream for this cycle, advance one clock, sample 1 unit later.
    task automatic tick();
        real u0, u1;
        case (mode)
            0: sd_in = 2'b11;
            1: sd_in = 2'b00;
            2: sd_in = {1'b1, (n % 2 == 0) ? 1'b1 : 1'b0};
            default: begin
                u0 = 0.5 * $sin(2.0 * PI * real'(osc_n) / 1024.0);
                u1 = 0.5 * $cos(2.0 * PI * real'(osc_n) / 1024.0);
                sd_in[0] = (acc0 >= 0.0);
                sd_in[1] = (acc1 >= 0.0);
                acc0 = acc0 + u0 - (sd_in[0] ? 1.0 : -1.0);
                acc1 = acc1 + u1 - (sd_in[1] ? 1.0 : -1.0);
                osc_n++;
            end
        endcase
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n = 0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int seen, t, vcount;
        logic found;
        real r;

        vecs[0]  = '{0, 1,   39711,   39711};
        vecs[1]  = '{0, 2,  214242,  214242};
        vecs[2]  = '{0, 3,  262143,  262143};
        vecs[3]  = '{0, 5,  262144,  262144};
        vecs[4]  = '{0, 6,  262144,  262144};
        vecs[5]  = '{1, 1,  -39711,  -39711};
        vecs[6]  = '{1, 3, -262143, -262143};
        vecs[7]  = '{1, 5, -262144, -262144};
        vecs[8]  = '{1, 7, -262144, -262144};
        vecs[9]  = '{2, 5,       0,  262144};
        vecs[10] = '{2, 6,       0,  262144};
        vecs[11] = '{2, 8,       0,  262144};

        // Reset state
        mode = 0;
        do_reset();
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_out0", int'(out0_data), 0);
        chk("reset_out1", int'(out1_data), 0);

        // Table-driven steady-state and start-up vectors
        for (int v = 0; v < 12; v++) begin
            mode = vecs[v].mode;
            out_ready = 1'b1;
            do_reset();
            seen = 0;
            t = 0;
            found = 1'b0;
            while (!found && t < 64 * vecs[v].idx + 16) begin
                tick();
                t++;
                if (out_valid) begin
                    seen++;
                    if (seen == vecs[v].idx) found = 1'b1;
                end
            end
            if (!found) begin
                chk($sformatf("vec%0d_timeout", v), 0, 1);
            end else begin
                chk($sformatf("vec%0d_time", v), t, 64 * vecs[v].idx);
                chk($sformatf("vec%0d_out0", v), int'(out0_data), vecs[v].exp0);
                chk($sformatf("vec%0d_out1", v), int'(out1_data), vecs[v].exp1);
            end
        end

        // Consumer stalled across two strobes: overwrite and sticky overrun
        mode = 0;
        out_ready = 1'b0;
        do_reset();
        ticks(64);
        chk("stall_valid1", int'(out_valid), 1);
        chk("stall_out0_1", int'(out0_data), 39711);
        chk("stall_ovr1", int'(overrun), 0);
        ticks(64);
        chk("stall_valid2", int'(out_valid), 1);
        chk("stall_out0_2", int'(out0_data), 214242);
        chk("stall_out1_2", int'(out1_data), 214242);
        chk("stall_ovr2", int'(overrun), 1);
        out_ready = 1'b1;
        tick();
        chk("accept_valid", int'(out_valid), 0);
        chk("accept_hold", int'(out0_data), 214242);
        chk("accept_ovr", int'(overrun), 1);
        ticks(63);
        chk("next_valid", int'(out_valid), 1);
        chk("next_out0", int'(out0_data), 262143);
        chk("next_ovr", int'(overrun), 1);

        // Acceptance coinciding with a strobe: reload, valid stays, no overrun
        out_ready = 1'b0;
        do_reset();
        ticks(127);
        chk("coinc_pre_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("coinc_valid", int'(out_valid), 1);
        chk("coinc_out0", int'(out0_data), 214242);
        chk("coinc_ovr", int'(overrun), 0);
        tick();
        chk("coinc_after_valid", int'(out_valid), 0);

        // Oscillator stream, stalled consumer, then reset at cnt=30
        mode = 3;
        out_ready = 1'b0;
        do_reset();
        ticks(128 + 30);
        chk("osc_pre_ovr", int'(overrun), 1);
        chk("osc_pre_valid", int'(out_valid), 1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_ovr", int'(overrun), 0);
        chk("midrst_out0", int'(out0_data), 0);
        chk("midrst_out1", int'(out1_data), 0);
        reset = 1'b0;
        n = 0;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("midrst_no_early_valid", vcount, 0);
        tick();
        chk("midrst_first_valid_at_64", int'(out_valid), 1);

        // Recovered channels: quadrature sinusoids, amplitude ~0.5*R^3 less droop
        seen = 1;
        t = 0;
        while (seen < 20 && t < 64 * 20 + 16) begin
            tick();
            t++;
            if (out_valid) begin
                seen++;
                if (seen >= 5) begin
                    r = $sqrt(real'(int'(out0_data)) * real'(int'(out0_data)) +
                              real'(int'(out1_data)) * real'(int'(out1_data)));
                    chk_rng($sformatf("osc_radius_%0d", seen), int'(r), 110000, 150000);
                end
            end
        end
        if (seen < 20) chk("osc_timeout", seen, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
